rf_wb_ctrl: RTL and testbench

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

---
 rtl/rf_ctrl_pkg.sv | 12 +
 rtl/rr_arb2.sv | 38 +++
 rtl/rf_wb_ctrl.sv | 99 +++++++++
 tb/tb_rf_wb_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and default widths for the register-file writeback controller.
package rf_ctrl_pkg;

    typedef enum logic {
        SRC_EX  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: the source not granted last wins a contention.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n_i,
    input  logic req_ex_i,
    input  logic req_mem_i,
    output logic gnt_ex_o,
    output logic gnt_mem_o
);
    import rf_ctrl_pkg::*;

    src_e last_q;
    src_e last_d;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= SRC_MEM;
        end else begin
            last_q <= last_d;
        end
    end

    // Grants are masked while reset is held so no request is taken during reset.
    always_comb begin
        gnt_ex_o  = rst_n_i & req_ex_i  & (~req_mem_i | (last_q == SRC_MEM));
        gnt_mem_o = rst_n_i & req_mem_i & (~req_ex_i  | (last_q == SRC_EX));
    end

    always_comb begin
        last_d = last_q;
        if (gnt_ex_o) begin
            last_d = SRC_EX;
        end else if (gnt_mem_o) begin
            last_d = SRC_MEM;
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: arbitrates EX/MEM writebacks into one
// registered write port and tracks outstanding destinations for hazard queries.
module rf_wb_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned addr_width_p = ADDR_W_DEF,
    parameter int unsigned data_width_p = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n_i,
    input  logic                    ex_valid_i,
    input  logic [addr_width_p-1:0] ex_addr_i,
    input  logic [data_width_p-1:0] ex_data_i,
    output logic                    ex_ready_o,
    input  logic                    mem_valid_i,
    input  logic [addr_width_p-1:0] mem_addr_i,
    input  logic [data_width_p-1:0] mem_data_i,
    output logic                    mem_ready_o,
    input  logic                    issue_i,
    input  logic [addr_width_p-1:0] issue_addr_i,
    input  logic [addr_width_p-1:0] rs_addr_i,
    input  logic [addr_width_p-1:0] rd_addr_i,
    output logic                    rs_busy_o,
    output logic                    rd_busy_o,
    output logic                    wen_o,
    output logic [addr_width_p-1:0] w_addr_o,
    output logic [data_width_p-1:0] w_data_o
);

    localparam int unsigned REGS = 1 << addr_width_p;

    logic                    gnt_ex;
    logic                    gnt_mem;
    logic                    wen_q,    wen_d;
    logic [addr_width_p-1:0] w_addr_q, w_addr_d;
    logic [data_width_p-1:0] w_data_q, w_data_d;
    logic [REGS-1:0]         pend_q,   pend_d;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n_i   (rst_n_i),
        .req_ex_i  (ex_valid_i),
        .req_mem_i (mem_valid_i),
        .gnt_ex_o  (gnt_ex),
        .gnt_mem_o (gnt_mem)
    );

    assign ex_ready_o  = gnt_ex;
    assign mem_ready_o = gnt_mem;

    always_comb begin
        wen_d    = gnt_ex | gnt_mem;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (gnt_ex) begin
            w_addr_d = ex_addr_i;
            w_data_d = ex_data_i;
        end else if (gnt_mem) begin
            w_addr_d = mem_addr_i;
            w_data_d = mem_data_i;
        end
    end

    // Set is applied after clear so a same-address issue and retire leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        if (wen_q) begin
            pend_d[w_addr_q] = 1'b0;
        end
        if (issue_i) begin
            pend_d[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wen_q    <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            pend_q   <= '0;
        end else begin
            wen_q    <= wen_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            pend_q   <= pend_d;
        end
    end

    // A register being written this cycle is already safe to read.
    always_comb begin
        rs_busy_o = pend_q[rs_addr_i] & ~(wen_q && (w_addr_q == rs_addr_i));
        rd_busy_o = pend_q[rd_addr_i] & ~(wen_q && (w_addr_q == rd_addr_i));
    end

    assign wen_o    = wen_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: directed writebacks, contention, hazard bits and reset.
module tb_rf_wb_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid, mem_valid, issue;
    logic [AW-1:0] ex_addr, mem_addr, issue_addr, rs_addr, rd_addr;
    logic [DW-1:0] ex_data, mem_data;
    logic          ex_ready, mem_ready, rs_busy, rd_busy, wen;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    always #5 clk = ~clk;

    rf_wb_ctrl #(.addr_width_p(AW), .data_width_p(DW)) dut (
        .clk          (clk),
        .rst_n_i      (rst_n),
        .ex_valid_i   (ex_valid),
        .ex_addr_i    (ex_addr),
        .ex_data_i    (ex_data),
        .ex_ready_o   (ex_ready),
        .mem_valid_i  (mem_valid),
        .mem_addr_i   (mem_addr),
        .mem_data_i   (mem_data),
        .mem_ready_o  (mem_ready),
        .issue_i      (issue),
        .issue_addr_i (issue_addr),
        .rs_addr_i    (rs_addr),
        .rd_addr_i    (rd_addr),
        .rs_busy_o    (rs_busy),
        .rd_busy_o    (rd_busy),
        .wen_o        (wen),
        .w_addr_o     (w_addr),
        .w_data_o     (w_data)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must match the next expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", w_addr, w_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chka("wr_addr", w_addr, mon_e.a);
                    chkd("wr_data", w_data, mon_e.d);
                end
            end
        end
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid  = 1'b0;
        mem_valid = 1'b0;
        issue     = 1'b0;
    endtask

    // One cycle of requests with hand-derived expected grants.
    task automatic step(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic xr, input logic mr, input string tag);
        ex_valid  = ev;
        ex_addr   = ea;
        ex_data   = ed;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        if (xr) exp_q.push_back(wr_t'({ea, ed}));
        else if (mr) exp_q.push_back(wr_t'({ma, md}));
        to_neg();
        chk1({tag, "_ex_ready"}, ex_ready, xr);
        chk1({tag, "_mem_ready"}, mem_ready, mr);
        to_next();
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        ex_valid  = 1'b1;
        mem_valid = 1'b1;
        #1;
        chk1({tag, "_rst_wen"}, wen, 1'b0);
        chka({tag, "_rst_waddr"}, w_addr, '0);
        chkd({tag, "_rst_wdata"}, w_data, '0);
        chk1({tag, "_rst_ex_ready"}, ex_ready, 1'b0);
        chk1({tag, "_rst_mem_ready"}, mem_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        to_next();
    endtask

    initial begin
        clear_inputs();
        ex_addr = '0; ex_data = '0; mem_addr = '0; mem_data = '0;
        issue_addr = '0; rs_addr = '0; rd_addr = '0;
        do_reset("init");

        // Single EX writeback, one-cycle latency, then idle holds address/data.
        step(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, "t033");
        clear_inputs();
        to_neg();
        chk1("t033_wen_hi", wen, 1'b1);
        to_next();
        to_neg();
        chk1("t033_wen_lo", wen, 1'b0);
        chka("t033_addr_hold", w_addr, 6'd5);
        chkd("t033_data_hold", w_data, 32'hDEADBEEF);
        to_next();

        // Four cycles of contention: EX, MEM, EX, MEM; accepted side advances its data.
        do_reset("t034");
        step(1'b1, 6'd1, 32'hAAAA0000, 1'b1, 6'd2, 32'hBBBB0000, 1'b1, 1'b0, "t034_c0");
        step(1'b1, 6'd1, 32'hAAAA0001, 1'b1, 6'd2, 32'hBBBB0000, 1'b0, 1'b1, "t034_c1");
        step(1'b1, 6'd1, 32'hAAAA0001, 1'b1, 6'd2, 32'hBBBB0001, 1'b1, 1'b0, "t034_c2");
        step(1'b1, 6'd1, 32'hAAAA0002, 1'b1, 6'd2, 32'hBBBB0001, 1'b0, 1'b1, "t034_c3");
        clear_inputs();
        to_next();
        to_next();

        // Same address from both sources: 0x11 then 0x22, the later one remains.
        do_reset("t035");
        step(1'b1, 6'd7, 32'h11, 1'b1, 6'd7, 32'h22, 1'b1, 1'b0, "t035_c0");
        step(1'b0, 6'd7, 32'h0,  1'b1, 6'd7, 32'h22, 1'b0, 1'b1, "t035_c1");
        clear_inputs();
        to_next();
        to_neg();
        chka("t035_final_addr", w_addr, 6'd7);
        chkd("t035_final_data", w_data, 32'h22);
        to_next();

        // Pending bit set on issue, masked during the retiring write, clear after.
        issue = 1'b1;
        issue_addr = 6'd9;
        rs_addr = 6'd9;
        to_neg();
        chk1("t036_busy_before", rs_busy, 1'b0);
        to_next();
        issue = 1'b0;
        to_neg();
        chk1("t036_busy_set", rs_busy, 1'b1);
        to_next();
        step(1'b1, 6'd9, 32'h99, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, "t036_wr");
        clear_inputs();
        to_neg();
        chk1("t036_busy_retire", rs_busy, 1'b0);
        to_next();
        to_neg();
        chk1("t036_busy_after", rs_busy, 1'b0);
        to_next();

        // Write with no pending bit, while re-issuing the same address.
        step(1'b1, 6'd9, 32'h37, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, "t037_wr");
        clear_inputs();
        issue = 1'b1;
        issue_addr = 6'd9;
        rd_addr = 6'd9;
        to_neg();
        chk1("t037_busy_same", rd_busy, 1'b0);
        to_next();
        issue = 1'b0;
        to_neg();
        chk1("t037_busy_next", rd_busy, 1'b1);
        to_next();

        // Reset mid-cycle with a MEM request accepted: dropped, scoreboard wiped.
        issue = 1'b1;
        issue_addr = 6'd3;
        to_next();
        issue = 1'b0;
        rs_addr = 6'd3;
        to_neg();
        chk1("t038_busy_pre", rs_busy, 1'b1);
        to_next();
        mem_valid = 1'b1;
        mem_addr  = 6'd4;
        mem_data  = 32'h44;
        to_neg();
        chk1("t038_mem_ready", mem_ready, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("t038_wen_rst", wen, 1'b0);
        chka("t038_addr_rst", w_addr, '0);
        chkd("t038_data_rst", w_data, '0);
        chk1("t038_ready_rst", mem_ready, 1'b0);
        chk1("t038_busy_rst", rs_busy, 1'b0);
        chk1("t038_busy9_rst", rd_busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        to_next();
        to_neg();
        chk1("t038_no_write_1", wen, 1'b0);
        to_next();
        to_neg();
        chk1("t038_no_write_2", wen, 1'b0);
        chk1("t038_busy_post", rs_busy, 1'b0);
        to_next();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_writes: got %0d writes outstanding expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
